// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared types and the round-robin search helper for the UART TX arbiter.
package uart_tx_arbiter_pkg;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
  localparam int MAX_REQ = 32;
  localparam int MAX_REQ_W = $clog2(MAX_REQ);
  // Index of the first set bit of valid[n-1:0] searching from ptr+1 modulo n, or -1 if none.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
    int j;
    rr_pick = -1;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (valid[j[MAX_REQ_W-1:0]]) rr_pick = j;
      end
    end
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, winner is the first request after ptr.
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt_onehot,
  output logic [IW-1:0] o_gnt_id,
  output logic          o_any
);
  int w_pick;
  always_comb begin
    w_pick = rr_pick(MAX_REQ'(i_req), int'(i_ptr), N);
    o_any = w_pick >= 0;
    o_gnt_id = o_any ? IW'(w_pick) : '0;
    o_gnt_onehot = o_any ? N'(1) << o_gnt_id : '0;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-granular round-robin sharing of the UART TX FIFO write port.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DATA_W = 8,
  parameter int MAX_BURST = 16,
  parameter int IDLE_TO = 255,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ*DATA_W-1:0]   i_req_data,
  input  logic [N_REQ-1:0]          i_req_last,
  output logic [N_REQ-1:0]          o_req_ready,
  input  logic                      i_fifo_full,
  output logic                      o_fifo_wrreq,
  output logic [DATA_W-1:0]         o_fifo_data,
  output logic [IW-1:0]             o_grant_id,
  output logic                      o_busy,
  output logic [7:0]                o_force_cnt
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(IDLE_TO + 1);
  arb_state_t r_state, w_next;
  logic [IW-1:0] r_grant, r_ptr, w_pick_id;
  logic [N_REQ-1:0] r_grant_oh, w_pick_oh;
  logic [BW-1:0] r_burst;
  logic [TW-1:0] r_idle;
  logic [7:0] r_force;
  logic w_any, w_busy, w_g_valid, w_g_last, w_xfer, w_rel_norm, w_rel_force;
  logic [DATA_W-1:0] w_g_data;
  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .i_req(i_req_valid),
    .i_ptr(r_ptr),
    .o_gnt_onehot(w_pick_oh),
    .o_gnt_id(w_pick_id),
    .o_any(w_any)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ARB_IDLE;
    else r_state <= w_next;
  end
  // A burst-limit hit on a last byte is a normal release, so the force path excludes last.
  always_comb begin
    w_busy = r_state == ARB_GRANT;
    w_g_valid = |(i_req_valid & r_grant_oh);
    w_g_last = |(i_req_last & r_grant_oh);
    w_g_data = i_req_data[r_grant*DATA_W +: DATA_W];
    w_xfer = w_busy & w_g_valid & ~i_fifo_full;
    w_rel_norm = w_xfer & w_g_last;
    w_rel_force = (w_xfer & ~w_g_last & (r_burst == BW'(MAX_BURST - 1)))
                | (w_busy & ~w_g_valid & (r_idle == TW'(IDLE_TO - 1)));
    w_next = w_busy ? ((w_rel_norm | w_rel_force) ? ARB_IDLE : ARB_GRANT)
                    : (w_any ? ARB_GRANT : ARB_IDLE);
    o_req_ready = (w_busy & ~i_fifo_full) ? r_grant_oh : '0;
    o_fifo_wrreq = w_xfer;
    o_fifo_data = w_xfer ? w_g_data : '0;
    o_grant_id = r_grant;
    o_busy = w_busy;
    o_force_cnt = r_force;
  end
  // Idle counter only advances while the owner has nothing to offer; a full-FIFO stall keeps it at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant <= '0;
      r_grant_oh <= '0;
      r_ptr <= IW'(N_REQ - 1);
      r_burst <= '0;
      r_idle <= '0;
      r_force <= '0;
    end else begin
      if (!w_busy && w_any) begin
        r_grant <= w_pick_id;
        r_grant_oh <= w_pick_oh;
        r_ptr <= w_pick_id;
        r_burst <= '0;
        r_idle <= '0;
      end
      if (w_xfer) r_burst <= r_burst + 1'b1;
      if (w_busy) r_idle <= w_g_valid ? '0 : r_idle + 1'b1;
      if (w_rel_force && r_force != 8'hFF) r_force <= r_force + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a message-level round-robin reference model.
module tb_uart_tx_arbiter;
  localparam int N = 2;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int ITO = 255;
  typedef struct packed {logic [DW-1:0] d; logic last;} byte_t;
  typedef struct packed {logic [DW-1:0] d; logic [7:0] id;} wr_t;
  logic clk = 0, rst = 1;
  logic [N-1:0] i_req_valid = '0, i_req_last = '0, o_req_ready;
  logic [N*DW-1:0] i_req_data = '0;
  logic i_fifo_full = 0, o_fifo_wrreq, o_busy;
  logic [DW-1:0] o_fifo_data;
  logic [0:0] o_grant_id;
  logic [7:0] o_force_cnt;
  byte_t rq[N][$];
  byte_t mq[N][$];
  wr_t exp_q[$];
  int wr_cyc[$];
  int checks = 0, errors = 0, cyc = 0, n_wr = 0;
  int m_ptr = N - 1, m_force = 0, full_rate = 0;
  bit force_full = 0;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .IDLE_TO(ITO)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .i_req_last(i_req_last),
    .o_req_ready(o_req_ready), .i_fifo_full(i_fifo_full),
    .o_fifo_wrreq(o_fifo_wrreq), .o_fifo_data(o_fifo_data),
    .o_grant_id(o_grant_id), .o_busy(o_busy), .o_force_cnt(o_force_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push_b(input int i, input logic [DW-1:0] d, input logic last);
    byte_t b;
    b.d = d;
    b.last = last;
    rq[i].push_back(b);
    mq[i].push_back(b);
  endtask

  task automatic push_msg(input int i, input int len, input bit with_last);
    for (int k = 0; k < len; k++) push_b(i, DW'($urandom_range(255)), with_last && k == len - 1);
  endtask

  // Reference: whole grants in round-robin order; a grant ends on last, MB bytes, or a dry stream.
  task automatic plan();
    int i, cnt;
    byte_t b;
    while (1) begin
      i = -1;
      for (int k = 1; k <= N; k++) if (i < 0 && mq[(m_ptr + k) % N].size() > 0) i = (m_ptr + k) % N;
      if (i < 0) break;
      m_ptr = i;
      cnt = 0;
      while (1) begin
        b = mq[i].pop_front();
        exp_q.push_back({b.d, 8'(i)});
        cnt++;
        if (b.last) break;
        if (cnt == MB || mq[i].size() == 0) begin
          if (m_force < 255) m_force++;
          break;
        end
      end
    end
  endtask

  function automatic bit rq_empty();
    rq_empty = 1;
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) rq_empty = 0;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    bit done = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = rq_empty() && exp_q.size() == 0 && !o_busy;
    end
    chk({tag, "_drain"}, done, 1);
    if (!done) begin
      exp_q.delete();
      for (int i = 0; i < N; i++) rq[i].delete();
    end
    chk({tag, "_force_cnt"}, o_force_cnt, m_force);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k = 0;
    while (n_wr < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_writes", n_wr >= n, 1);
  endtask

  task automatic do_reset(input bit check_outs);
    @(negedge clk);
    #2 rst = 1;
    for (int i = 0; i < N; i++) begin
      rq[i].delete();
      mq[i].delete();
    end
    exp_q.delete();
    m_ptr = N - 1;
    m_force = 0;
    #1;
    if (check_outs) begin
      chk("rst_busy", o_busy, 0);
      chk("rst_wrreq", o_fifo_wrreq, 0);
      chk("rst_ready", o_req_ready, 0);
      chk("rst_data", o_fifo_data, 0);
      chk("rst_grant", o_grant_id, 0);
      chk("rst_force", o_force_cnt, 0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    logic [N-1:0] hs;
    forever begin
      @(negedge clk);
      hs = i_req_valid & o_req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!rst && hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        i_req_valid[i] = rq[i].size() > 0;
        i_req_data[i*DW +: DW] = rq[i].size() > 0 ? rq[i][0].d : '0;
        i_req_last[i] = rq[i].size() > 0 && rq[i][0].last;
      end
      i_fifo_full = force_full || ($urandom_range(99) < full_rate);
    end
  end

  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (i_fifo_full) begin
          chk("full_wrreq", o_fifo_wrreq, 0);
          chk("full_ready", o_req_ready, 0);
        end
        if (o_fifo_wrreq) begin
          chk("exp_avail", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_data", o_fifo_data, e.d);
            chk("wr_id", o_grant_id, e.id);
          end
          n_wr++;
          wr_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t0, base;
    repeat (3) @(negedge clk);
    chk("reset_busy", o_busy, 0);
    chk("reset_wrreq", o_fifo_wrreq, 0);
    chk("reset_ready", o_req_ready, 0);
    chk("reset_data", o_fifo_data, 0);
    chk("reset_grant", o_grant_id, 0);
    chk("reset_force", o_force_cnt, 0);
    rst = 0;
    // single requester, three-byte message
    @(negedge clk);
    base = n_wr;
    t0 = cyc;
    push_b(0, 8'h41, 0);
    push_b(0, 8'h42, 0);
    push_b(0, 8'h43, 1);
    plan();
    drain("single", 100);
    chk("single_first_cyc", wr_cyc.size() > base ? wr_cyc[base] - t0 : -1, 2);
    chk("single_last_cyc", wr_cyc.size() > base + 2 ? wr_cyc[base+2] - t0 : -1, 4);
    // both requesters from reset, two rounds
    do_reset(0);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      push_msg(1, 2, 1);
      push_msg(0, 2, 1);
      plan();
      drain("pair", 100);
    end
    // FIFO full held mid-message
    @(negedge clk);
    base = n_wr;
    push_msg(0, 6, 1);
    plan();
    wait_writes(base + 2, 50);
    force_full = 1;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("full_busy", o_busy, 1);
      chk("full_grant", o_grant_id, 0);
    end
    force_full = 0;
    drain("full_hold", 100);
    // burst limit forces a release to the other requester
    do_reset(0);
    @(negedge clk);
    push_msg(0, 3, 1);
    plan();
    drain("pre_burst", 100);
    @(negedge clk);
    push_msg(1, 20, 1);
    push_msg(0, 3, 1);
    plan();
    drain("burst", 200);
    chk("burst_force_one", o_force_cnt, 1);
    // granted requester goes silent
    @(negedge clk);
    base = n_wr;
    push_msg(0, 1, 0);
    push_msg(1, 2, 1);
    plan();
    drain("idle_to", 1000);
    chk("idle_gap", wr_cyc.size() > base + 1 ? wr_cyc[base+1] - wr_cyc[base] : -1, ITO + 2);
    chk("idle_force_two", o_force_cnt, 2);
    // randomized traffic with random FIFO backpressure
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      full_rate = $urandom_range(40);
      for (int i = 0; i < N; i++)
        repeat ($urandom_range(3)) push_msg(i, $urandom_range(40, 1), 1);
      plan();
      drain("random", 5000);
    end
    full_rate = 0;
    // force_cnt saturation
    @(negedge clk);
    for (int g = 0; g < 259; g++) push_msg(0, MB, g == 258);
    plan();
    drain("saturate", 10000);
    chk("saturate_255", o_force_cnt, 255);
    // reset mid-message, then requester 0 wins first again
    @(negedge clk);
    base = n_wr;
    push_msg(0, 10, 1);
    plan();
    wait_writes(base + 3, 50);
    do_reset(1);
    @(negedge clk);
    push_msg(1, 2, 1);
    push_msg(0, 2, 1);
    plan();
    drain("after_rst", 100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
